// File: rtl/snake_game_sequencer.sv
// Snake game sequencer: owns game state, move timing, steering and scoring.
// The position datapath does the geometry; this block decides when it moves,
// in which direction, and what happens when the head lands on food or body.
module snake_game_sequencer #(
  parameter int TICK_DIV = 1666666,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 99
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  buttons,
  input  logic        start,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  input  logic [9:0]  food_x,
  input  logic [9:0]  food_y,
  input  logic        self_hit,
  output logic        move_tick,
  output logic [1:0]  dir,
  output logic [9:0]  length,
  output logic [15:0] score,
  output logic        snake_rst,
  output logic        food_req,
  output logic [1:0]  state
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0] LEN_INIT = 10'(INIT_LEN);
  localparam logic [9:0] LEN_MAX  = 10'(MAX_LEN);
  localparam logic [1:0] DIR_RIGHT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  tick_cnt;
  logic [1:0]        pending;
  logic              eval_q;
  logic [1:0]        btn_dir;
  logic              btn_accept;
  logic              food_hit;
  logic              start_go;

  assign state    = state_q;
  assign food_hit = (head_x == food_x) && (head_y == food_y);
  assign start_go = start && ((state_q == IDLE) || (state_q == DEAD));

  // Priority decode of the buttons and rejection of a straight reversal
  always_comb begin
    btn_dir = 2'd3;
    if (buttons[0])      btn_dir = 2'd0;
    else if (buttons[1]) btn_dir = 2'd1;
    else if (buttons[2]) btn_dir = 2'd2;
    btn_accept = (buttons != 4'b0000) && (btn_dir != (dir ^ 2'b10));
  end

  // Next-state logic; the spare encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      DEAD:    if (start) state_d = RUN;
      RUN:     if (eval_q && self_hit) state_d = DEAD;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Tick timing, steering, scoring and the one-cycle control pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt  <= '0;
      move_tick <= 1'b0;
      eval_q    <= 1'b0;
      snake_rst <= 1'b0;
      food_req  <= 1'b0;
      dir       <= DIR_RIGHT;
      pending   <= DIR_RIGHT;
      length    <= '0;
      score     <= '0;
    end else begin
      move_tick <= 1'b0;
      snake_rst <= 1'b0;
      food_req  <= 1'b0;
      eval_q    <= 1'b0;
      if (start_go) begin
        tick_cnt  <= '0;
        dir       <= DIR_RIGHT;
        pending   <= DIR_RIGHT;
        length    <= LEN_INIT;
        score     <= '0;
        snake_rst <= 1'b1;
      end else begin
        if (btn_accept) pending <= btn_dir;
        if (state_q == RUN) begin
          eval_q <= move_tick;
          if (move_tick) dir <= pending;
          if (eval_q && !self_hit && food_hit) begin
            food_req <= 1'b1;
            if (length < LEN_MAX) length <= length + 10'd1;
            if (score != 16'hFFFF) score <= score + 16'd1;
          end
        end
        if (state_q == RUN && state_d == RUN) begin
          if (tick_cnt == CNT_LAST) begin
            tick_cnt  <= '0;
            move_tick <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end else begin
          tick_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Self-checking bench for snake_game_sequencer with a short tick period.
module tb_snake_game_sequencer;

  localparam int MAXL = 99;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  buttons;
  logic        start;
  logic [9:0]  head_x, head_y, food_x, food_y;
  logic        self_hit;
  logic        move_tick;
  logic [1:0]  dir;
  logic [9:0]  length;
  logic [15:0] score;
  logic        snake_rst;
  logic        food_req;
  logic [1:0]  state;

  int    checkCount = 0;
  int    errCount   = 0;
  string tag_q[$];
  int    exp_q[$];
  int    exp_len;
  int    exp_score;

  snake_game_sequencer #(.TICK_DIV(4), .INIT_LEN(3), .MAX_LEN(MAXL)) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .start(start),
    .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
    .self_hit(self_hit), .move_tick(move_tick), .dir(dir), .length(length),
    .score(score), .snake_rst(snake_rst), .food_req(food_req), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input int value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic popCheck(input int actual);
    string t;
    int e;
    if (exp_q.size() == 0) begin
      checkOutput("sb_underflow", exp_q.size(), 1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      checkOutput(t, actual, e);
    end
  endtask

  task automatic waitTick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (move_tick) seen = 1'b1;
    end
    if (!seen) checkOutput("tick_timeout", int'(move_tick), 1);
  endtask

  task automatic applyStimulus(input logic [3:0] b);
    buttons = b;
    step();
    buttons = 4'b0000;
  endtask

  task automatic eatOnce(input logic hit);
    waitTick();
    head_x   = food_x;
    head_y   = food_y;
    self_hit = hit;
    if (!hit) begin
      exp_len = (exp_len < MAXL) ? exp_len + 1 : MAXL;
      exp_score++;
    end
    pushExpect("length", exp_len);
    pushExpect("score", exp_score);
    pushExpect("food_req", hit ? 0 : 1);
    pushExpect("state", hit ? 2 : 1);
    step();
    step();
    popCheck(length);
    popCheck(score);
    popCheck(food_req);
    popCheck(state);
    head_x   = 10'd1;
    head_y   = 10'd1;
    self_hit = 1'b0;
    step();
    checkOutput("food_req_pulse", food_req, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; buttons = 4'b0000; self_hit = 1'b0;
    head_x = 10'd1; head_y = 10'd1; food_x = 10'd100; food_y = 10'd50;
    step(); step();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_length", length, 0);
    checkOutput("rst_score", score, 0);
    checkOutput("rst_dir", dir, 2);
    checkOutput("rst_move_tick", move_tick, 0);
    checkOutput("rst_snake_rst", snake_rst, 0);
    checkOutput("rst_food_req", food_req, 0);
    reset = 1'b0;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("start_snake_rst", snake_rst, 1);
    checkOutput("start_state", state, 1);
    checkOutput("start_length", length, 3);
    checkOutput("start_score", score, 0);
    exp_len = 3;
    exp_score = 0;

    pushExpect("tick_cycle", 4);
    pushExpect("tick_cycle", 8);
    pushExpect("tick_cycle", 12);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) checkOutput("snake_rst_pulse", snake_rst, 0);
      if (move_tick) popCheck(c);
    end
    checkOutput("tick_left", exp_q.size(), 0);
    tag_q.delete();
    exp_q.delete();

    applyStimulus(4'b0001);
    applyStimulus(4'b0011);
    pushExpect("dir_reject_left", 2);
    waitTick(); step();
    popCheck(dir);

    applyStimulus(4'b0110);
    pushExpect("dir_down_priority", 1);
    waitTick(); step();
    popCheck(dir);

    applyStimulus(4'b0100);
    pushExpect("dir_right", 2);
    waitTick(); step();
    popCheck(dir);

    applyStimulus(4'b1000);
    checkOutput("dir_stable", dir, 2);
    pushExpect("dir_up", 3);
    waitTick();
    checkOutput("dir_before_commit", dir, 2);
    step();
    popCheck(dir);
    step();

    for (int i = 0; i < 100; i++) begin
      eatOnce(1'b0);
      if (i == 5) begin
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("run_start_snake_rst", snake_rst, 0);
        checkOutput("run_start_length", length, exp_len);
        checkOutput("run_start_score", score, exp_score);
      end
    end

    eatOnce(1'b1);
    buttons = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("dead_move_tick", move_tick, 0);
    end
    buttons = 4'b0000;
    checkOutput("dead_state", state, 2);
    checkOutput("dead_length", length, exp_len);
    checkOutput("dead_score", score, exp_score);
    checkOutput("dead_dir", dir, 3);

    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("restart_state", state, 1);
    checkOutput("restart_length", length, 3);
    checkOutput("restart_score", score, 0);
    checkOutput("restart_dir", dir, 2);
    checkOutput("restart_snake_rst", snake_rst, 1);

    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midrst_state", state, 0);
    checkOutput("midrst_move_tick", move_tick, 0);
    checkOutput("midrst_snake_rst", snake_rst, 0);
    checkOutput("midrst_food_req", food_req, 0);
    checkOutput("midrst_dir", dir, 2);
    checkOutput("midrst_length", length, 0);
    checkOutput("midrst_score", score, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("idle_move_tick", move_tick, 0);
    end
    checkOutput("idle_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
